// File: rtl/pattern_pwm_rx_pkg.sv
// Shared definitions for the pattern PWM receiver: state encoding, duty width, default start latency.
// The PAT_RX_MAJORITY_EN build option uses maj3 from here.
package pattern_pwm_rx_pkg;

  localparam int DUTY_W        = 8;
  localparam int START_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BIT  = 2'd2,
    ST_DONE = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pattern_pwm_rx_sampler.sv
// Mid-bit sampler: strobes once per bit and supplies the bit value.
// With PAT_RX_MAJORITY_EN defined, votes over three samples around mid-bit when dn >= 2.
module pattern_pwm_rx_sampler
  import pattern_pwm_rx_pkg::*;
(
`ifdef PAT_RX_MAJORITY_EN
  input  logic              clk,
  input  logic              rst_n,
`endif
  input  logic              i_en,
  input  logic [DUTY_W-1:0] i_duty_cnt,
  input  logic [DUTY_W-1:0] i_dn,
  input  logic              i_pwm,
  output logic              o_strobe,
  output logic              o_bit
);

  logic [DUTY_W-1:0] w_mid;
  assign w_mid = i_dn >> 1;

`ifdef PAT_RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;
  logic w_vote;
  assign w_vote = (i_dn >= 8'd2);

  // Capture the m-1 and m samples; the m+1 sample is taken live at the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      if (i_en && (i_duty_cnt == (w_mid - 8'd1))) begin
        r_s0 <= i_pwm;
      end else begin
        r_s0 <= r_s0;
      end
      if (i_en && (i_duty_cnt == w_mid)) begin
        r_s1 <= i_pwm;
      end else begin
        r_s1 <= r_s1;
      end
    end
  end

  assign o_strobe = i_en && (w_vote ? (i_duty_cnt == (w_mid + 8'd1)) : (i_duty_cnt == w_mid));
  assign o_bit    = w_vote ? maj3(r_s0, r_s1, i_pwm) : i_pwm;
`else
  assign o_strobe = i_en && (i_duty_cnt == w_mid);
  assign o_bit    = i_pwm;
`endif

endmodule

// File: rtl/pattern_pwm_rx.sv
// Pattern PWM receiver: recovers a _PAT_WIDTH-bit word sent LSB first, duty_num+1 clocks per bit.
// Build option PAT_RX_MAJORITY_EN selects three-sample majority voting in the sampler.
module pattern_pwm_rx
  import pattern_pwm_rx_pkg::*;
#(
  parameter int _PAT_WIDTH = 8,
  parameter int START_LAT  = START_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_en,
  input  logic [DUTY_W-1:0]     duty_num,
  input  logic [_PAT_WIDTH-1:0] exp_pat,
  input  logic                  pwm_in,
  output logic [_PAT_WIDTH-1:0] pat_out,
  output logic                  busy,
  output logic                  valid,
  output logic                  match,
  output logic                  ovr
);

  localparam int BIT_W = $clog2(_PAT_WIDTH);

  rx_state_e             r_state;
  rx_state_e             w_next;
  logic [DUTY_W-1:0]     r_dn;
  logic [_PAT_WIDTH-1:0] r_exp;
  logic [DUTY_W-1:0]     r_lat_cnt;
  logic [DUTY_W-1:0]     r_duty_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [_PAT_WIDTH-1:0] r_shift;
  logic [_PAT_WIDTH-1:0] r_pat_out;
  logic                  r_valid;
  logic                  r_match;
  logic                  r_busy;
  logic                  r_ovr;

  logic                  w_strobe;
  logic                  w_bit;
  logic                  w_duty_last;
  logic                  w_bit_last;
  logic                  w_lat_last;
  logic [_PAT_WIDTH-1:0] w_shift_next;

  pattern_pwm_rx_sampler u_sampler (
`ifdef PAT_RX_MAJORITY_EN
    .clk        (clk),
    .rst_n      (rst_n),
`endif
    .i_en       (r_state == ST_BIT),
    .i_duty_cnt (r_duty_cnt),
    .i_dn       (r_dn),
    .i_pwm      (pwm_in),
    .o_strobe   (w_strobe),
    .o_bit      (w_bit)
  );

  assign w_duty_last  = (r_duty_cnt == r_dn);
  assign w_bit_last   = (r_bit_cnt == BIT_W'(_PAT_WIDTH - 1));
  assign w_lat_last   = (r_lat_cnt == DUTY_W'(START_LAT - 2));
  // The final sample may coincide with the DONE transition (dn=0), so results use the post-shift value.
  assign w_shift_next = w_strobe ? {w_bit, r_shift[_PAT_WIDTH-1:1]} : r_shift;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_en) begin
          w_next = (START_LAT == 1) ? ST_BIT : ST_WAIT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_lat_last) begin
          w_next = ST_BIT;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_BIT: begin
        if (w_duty_last && w_bit_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_BIT;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dn       <= '0;
      r_exp      <= '0;
      r_lat_cnt  <= '0;
      r_duty_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_pat_out  <= '0;
      r_valid    <= 1'b0;
      r_match    <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ovr   <= rx_en && (r_state != ST_IDLE);
      r_valid <= (w_next == ST_DONE);
      r_busy  <= (w_next == ST_WAIT) || (w_next == ST_BIT);
      case (r_state)
        ST_IDLE: begin
          if (rx_en) begin
            r_dn       <= duty_num;
            r_exp      <= exp_pat;
            r_lat_cnt  <= '0;
            r_duty_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
          end else begin
            r_dn <= r_dn;
          end
        end
        ST_WAIT: r_lat_cnt <= r_lat_cnt + 8'd1;
        ST_BIT: begin
          r_shift <= w_shift_next;
          if (w_duty_last) begin
            r_duty_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
          end else begin
            r_duty_cnt <= r_duty_cnt + 8'd1;
          end
        end
        ST_DONE: r_duty_cnt <= '0;
        default: r_duty_cnt <= '0;
      endcase
      if (w_next == ST_DONE) begin
        r_pat_out <= w_shift_next;
        r_match   <= (w_shift_next == r_exp);
      end else begin
        r_pat_out <= r_pat_out;
      end
    end
  end

  assign pat_out = r_pat_out;
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign match   = r_match;
  assign ovr     = r_ovr;

endmodule
